// File: rtl/vga_timing_gen_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster generator.
package vga_timing_pkg;

    // Phase of one raster axis (horizontal or vertical)
    typedef enum logic [1:0] {
        ACT   = 2'd0,
        FRONT = 2'd1,
        SYN   = 2'd2,
        BACK  = 2'd3
    } phase_e;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    // Clocks (or lines) in one full period of an axis
    function automatic int unsigned axis_total(input int unsigned act,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Video-side bundle of the VGA timing generator: restart in, coordinates,
// strobes and delayed DAC timing out.
interface vga_timing_gen_if;

    logic        restart;
    logic [9:0]  xCoord;
    logic [9:0]  yCoord;
    logic        coord_valid;
    logic        line_start;
    logic        frame_start;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        visible;
    logic        VGA_SYNC_N;
    logic        pixelClk;
    logic [15:0] frame_count;

    // Timing generator side
    modport master (
        input  restart,
        output xCoord, yCoord, coord_valid, line_start, frame_start,
               VGA_HS, VGA_VS, visible, VGA_SYNC_N, pixelClk, frame_count
    );

    // Video memory / DAC side
    modport slave (
        output restart,
        input  xCoord, yCoord, coord_valid, line_start, frame_start,
               VGA_HS, VGA_VS, visible, VGA_SYNC_N, pixelClk, frame_count
    );

endinterface

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: ACT->FRONT->SYN->BACK phase FSM with a per-phase down
// counter, a position counter 0..total-1, and an end-of-period wrap flag.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW     = 11,
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       step_i,
    input  logic       restart_i,
    output phase_e     phase_o,
    output logic [9:0] coord_o,
    output logic       wrap_o
);

    localparam logic [CW-1:0] ACT_M1  = CW'(ACTIVE - 1);
    localparam logic [CW-1:0] FP_M1   = CW'(FP - 1);
    localparam logic [CW-1:0] SYNC_M1 = CW'(SYNC - 1);
    localparam logic [CW-1:0] BP_M1   = CW'(BP - 1);

    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_len_chk
        $error("vga_axis_counter: every phase length must be non-zero");
    end
    if (CW < 10 || axis_total(ACTIVE, FP, SYNC, BP) > (2 ** CW)) begin : g_cw_chk
        $error("vga_axis_counter: CW too small for the axis total");
    end

    phase_e        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pos_q, pos_d;
    logic          wrap;

    assign wrap = step_i && (phase_q == BACK) && (cnt_q == '0);

    // Next phase/count/position; restart beats any step or wrap
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        if (restart_i) begin
            phase_d = ACT;
            cnt_d   = ACT_M1;
            pos_d   = '0;
        end else if (step_i) begin
            pos_d = wrap ? '0 : pos_q + 1'b1;
            if (cnt_q == '0) begin
                unique case (phase_q)
                    ACT:   begin phase_d = FRONT; cnt_d = FP_M1;   end
                    FRONT: begin phase_d = SYN;   cnt_d = SYNC_M1; end
                    SYN:   begin phase_d = BACK;  cnt_d = BP_M1;   end
                    BACK:  begin phase_d = ACT;   cnt_d = ACT_M1;  end
                endcase
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Axis state registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= ACT;
            cnt_q   <= ACT_M1;
            pos_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
        end
    end

    assign phase_o = phase_q;
    assign coord_o = pos_q[9:0];
    assign wrap_o  = wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with programmable porches, sync
// polarity, coordinate down-scaling and a sync/visible delay line.
// Optional frame counter: define VGA_FRAME_COUNTER_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter bit          HS_POL      = 1'b0,
    parameter bit          VS_POL      = 1'b0,
    parameter int unsigned SCALE_SHIFT = 0,
    parameter int unsigned PIPE_DELAY  = 2,
    parameter int unsigned CW          = 11
) (
    input  logic             vga_clock,
    input  logic             resetn,
    vga_timing_gen_if.master vga
);

    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_pipe_chk
        $error("vga_timing_gen: PIPE_DELAY must be 1..4");
    end

    phase_e     h_phase, v_phase;
    logic [9:0] h_coord, v_coord;
    logic       h_wrap, v_wrap;

    vga_axis_counter #(
        .CW     (CW),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk_i     (vga_clock),
        .rst_n_i   (resetn),
        .step_i    (1'b1),
        .restart_i (vga.restart),
        .phase_o   (h_phase),
        .coord_o   (h_coord),
        .wrap_o    (h_wrap)
    );

    vga_axis_counter #(
        .CW     (CW),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk_i     (vga_clock),
        .rst_n_i   (resetn),
        .step_i    (h_wrap),
        .restart_i (vga.restart),
        .phase_o   (v_phase),
        .coord_o   (v_coord),
        .wrap_o    (v_wrap)
    );

    logic hs_raw, vs_raw, valid_raw;
    assign hs_raw    = (h_phase == SYN) ? HS_POL : ~HS_POL;
    assign vs_raw    = (v_phase == SYN) ? VS_POL : ~VS_POL;
    assign valid_raw = (h_phase == ACT) && (v_phase == ACT);

    // Position (0,0) is only ever entered through reset, restart or a full
    // wrap, so the strobes are registered from those events instead of
    // decoding the counters; the observable timing is identical.
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;
    assign line_start_d  = vga.restart | h_wrap;
    assign frame_start_d = vga.restart | (h_wrap & v_wrap);

    // Start-of-line / start-of-frame strobes
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            line_start_q  <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DELAY-1:0] vis_pipe_q, vis_pipe_d;
    assign hs_pipe_d  = PIPE_DELAY'({hs_pipe_q, hs_raw});
    assign vs_pipe_d  = PIPE_DELAY'({vs_pipe_q, vs_raw});
    assign vis_pipe_d = PIPE_DELAY'({vis_pipe_q, valid_raw});

    // Delay line aligning sync/visible with video memory read latency;
    // restart deliberately leaves it to drain
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            hs_pipe_q  <= {PIPE_DELAY{~HS_POL}};
            vs_pipe_q  <= {PIPE_DELAY{~VS_POL}};
            vis_pipe_q <= '0;
        end else begin
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            vis_pipe_q <= vis_pipe_d;
        end
    end

`ifdef VGA_FRAME_COUNTER_EN
    logic [15:0] frame_count_q, frame_count_d;
    // Counts every frame_start except the one produced by reset itself,
    // including those caused by restart
    assign frame_count_d = frame_start_d ? frame_count_q + 1'b1 : frame_count_q;

    // Frame counter, cleared only by reset
    always_ff @(posedge vga_clock or negedge resetn) begin
        if (!resetn) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end
    assign vga.frame_count = frame_count_q;
`else
    assign vga.frame_count = '0;
`endif

    assign vga.xCoord      = h_coord >> SCALE_SHIFT;
    assign vga.yCoord      = v_coord >> SCALE_SHIFT;
    assign vga.coord_valid = valid_raw;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;
    assign vga.VGA_HS      = hs_pipe_q[PIPE_DELAY-1];
    assign vga.VGA_VS      = vs_pipe_q[PIPE_DELAY-1];
    assign vga.visible     = vis_pipe_q[PIPE_DELAY-1];
    assign vga.VGA_SYNC_N  = 1'b1;
    assign vga.pixelClk    = vga_clock;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: several parameter sets run side by side
// from one clock; expected values are hand-derived from the timing tables.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if if_def ();
    vga_timing_gen_if if_pol ();
    vga_timing_gen_if if_scl ();
    vga_timing_gen_if if_scy ();
    vga_timing_gen_if if_pd3 ();
    vga_timing_gen_if if_rst ();

    // 640x480 defaults
    vga_timing_gen u_def (.vga_clock(clk), .resetn(rst_n), .vga(if_def));

    // Active-high syncs, short frame: 8 lines, VS on lines 5..6
    vga_timing_gen #(
        .HS_POL(1'b1), .VS_POL(1'b1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_pol (.vga_clock(clk), .resetn(rst_n), .vga(if_pol));

    // Scale by 4 on a full-width line
    vga_timing_gen #(
        .SCALE_SHIFT(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_scl (.vga_clock(clk), .resetn(rst_n), .vga(if_scl));

    // Scale by 4 on full-height frame with 4-clock lines
    vga_timing_gen #(
        .SCALE_SHIFT(2),
        .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1)
    ) u_scy (.vga_clock(clk), .resetn(rst_n), .vga(if_scy));

    // Three-stage delay, 15x8 raster (120 clocks/frame)
    vga_timing_gen #(
        .PIPE_DELAY(3),
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_pd3 (.vga_clock(clk), .resetn(rst_n), .vga(if_pd3));

    // Restart target, 17x10 raster (170 clocks/frame)
    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_rst (.vga_clock(clk), .resetn(rst_n), .vga(if_rst));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    localparam int T_END = 6500;

    int   hs_low_cnt = 0, hs_first = -1, hs_last = -1;
    int   ls_first = -1, ls_second = -1;
    int   vis_rise = -1, vis_fall = -1;
    logic vis_prev = 1'b0;
    int   pol_vs_hi = 0, pol_hs_hi = 0;
    int   scl_xmax = 0, scy_ymax = 0;
    int   pd3_rise = -1;
    int   rst_fs_next = -1;

    initial begin
        rst_n = 1'b0;
        if_def.restart = 1'b0;
        if_pol.restart = 1'b0;
        if_scl.restart = 1'b0;
        if_scy.restart = 1'b0;
        if_pd3.restart = 1'b0;
        if_rst.restart = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_hs",      if_def.VGA_HS, 1);
        chk("rst_vs",      if_def.VGA_VS, 1);
        chk("rst_visible", if_def.visible, 0);
        chk("rst_valid",   if_def.coord_valid, 1);
        chk("rst_ls",      if_def.line_start, 1);
        chk("rst_fs",      if_def.frame_start, 1);
        chk("rst_x",       if_def.xCoord, 0);
        chk("rst_fc",      if_def.frame_count, 0);
        chk("rst_syncn",   if_def.VGA_SYNC_N, 1);
        chk("rst_pol_hs",  if_pol.VGA_HS, 0);
        chk("rst_pol_vs",  if_pol.VGA_VS, 0);

        rst_n = 1'b1;
        for (int t = 0; t < T_END; t++) begin
            // defaults: HS, line period, visible edges
            if (t < 800 && if_def.VGA_HS == 1'b0) begin
                hs_low_cnt++;
                if (hs_first < 0) hs_first = t;
                hs_last = t;
            end
            if (t > 0 && if_def.line_start) begin
                if (ls_first < 0) ls_first = t;
                else if (ls_second < 0) ls_second = t;
            end
            if (vis_rise < 0 && if_def.visible) vis_rise = t;
            if (vis_fall < 0 && vis_prev && !if_def.visible) vis_fall = t;
            vis_prev = if_def.visible;
            if (t == 700) chk("def_x700", if_def.xCoord, 700);
            if (t == 800) chk("def_fs_line1", if_def.frame_start, 0);

            // polarity
            if (if_pol.VGA_VS) pol_vs_hi++;
            if (t < 800 && if_pol.VGA_HS) pol_hs_hi++;

            // scaling
            if (t < 800 && if_scl.coord_valid && int'(if_scl.xCoord) > scl_xmax)
                scl_xmax = int'(if_scl.xCoord);
            if (t == 3) chk("scl_x3", if_scl.xCoord, 0);
            if (t == 4) chk("scl_x4", if_scl.xCoord, 1);
            if (t == 7) chk("scl_x7", if_scl.xCoord, 1);
            if (t == 8) chk("scl_x8", if_scl.xCoord, 2);
            if (t < 2100 && if_scy.coord_valid && int'(if_scy.yCoord) > scy_ymax)
                scy_ymax = int'(if_scy.yCoord);
            if (t == 12) chk("scy_y12", if_scy.yCoord, 0);
            if (t == 16) chk("scy_y16", if_scy.yCoord, 1);

            // pipe delay 3
            if (pd3_rise < 0 && if_pd3.visible) pd3_rise = t;
            if (t == 122) chk("pd3_vis122", if_pd3.visible, 0);
            if (t == 123) chk("pd3_vis123", if_pd3.visible, 1);

            // restart at (12,3)
            if (t == 63) begin
                chk("rst_pre_x", if_rst.xCoord, 12);
                chk("rst_pre_y", if_rst.yCoord, 3);
                if_rst.restart = 1'b1;
            end
            if (t == 64) begin
                if_rst.restart = 1'b0;
                chk("restart_x",  if_rst.xCoord, 0);
                chk("restart_y",  if_rst.yCoord, 0);
                chk("restart_fs", if_rst.frame_start, 1);
                chk("restart_ls", if_rst.line_start, 1);
            end
            if (t == 65) chk("restart_hs_drain", if_rst.VGA_HS, 0);
            if (t == 66) chk("restart_hs_new",   if_rst.VGA_HS, 1);
            if (t > 64 && rst_fs_next < 0 && if_rst.frame_start) rst_fs_next = t;
`ifdef VGA_FRAME_COUNTER_EN
            if (t == 0)   chk("fc_0", if_rst.frame_count, 0);
            if (t == 64)  chk("fc_1", if_rst.frame_count, 1);
            if (t == 234) chk("fc_2", if_rst.frame_count, 2);
            if (t == 404) chk("fc_3", if_rst.frame_count, 3);
`else
            if (t == 234) chk("fc_off", if_rst.frame_count, 0);
`endif
            @(negedge clk);
        end

        chk("def_hs_low_cnt",  hs_low_cnt, 96);
        chk("def_hs_first",    hs_first, 658);
        chk("def_hs_last",     hs_last, 753);
        chk("def_ls_first",    ls_first, 800);
        chk("def_line_period", ls_second - ls_first, 800);
        chk("def_vis_rise",    vis_rise, 2);
        chk("def_vis_fall",    vis_fall, 642);
        chk("pol_vs_hi",       pol_vs_hi, 1600);
        chk("pol_hs_hi",       pol_hs_hi, 96);
        chk("scl_xmax",        scl_xmax, 159);
        chk("scy_ymax",        scy_ymax, 119);
        chk("pd3_rise",        pd3_rise, 3);
        chk("restart_frame",   rst_fs_next, 234);

        // Asynchronous reset mid-frame, away from any clock edge
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_fc",    if_rst.frame_count, 0);
        chk("async_x",     if_def.xCoord, 0);
        chk("async_hs",    if_def.VGA_HS, 1);
        chk("async_vis",   if_pd3.visible, 0);
        chk("async_valid", if_rst.coord_valid, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the fixed 640x480 controller.
- Generalises the timing to arbitrary porch/sync/active values, programmable sync polarity, coordinate down-scaling and a configurable pipeline delay that aligns sync/visible with video-memory read latency.
- Adds line/frame strobes and a synchronous restart.
- Sits between the pixel-clock source and the video memory/DAC path. xCoord/yCoord address memory; delayed VGA_HS/VGA_VS/visible go to the DAC.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, asserted level of VGA_HS (0 = active-low)
- VS_POL, 0, asserted level of VGA_VS
- SCALE_SHIFT, 0, coordinate right-shift: 0 = 640x480, 1 = 320x240, 2 = 160x120
- PIPE_DELAY, 2, clocks from coordinate to VGA_HS/VGA_VS/visible; legal range 1..4
- CW, 11, internal counter width; must hold the larger total minus 1

Ports:
- vga_clock  input  1  pixel clock
- resetn  input  1  asynchronous reset, active-low
- restart  input  1  synchronous restart to position (0,0)
- xCoord  output  10  horizontal counter >> SCALE_SHIFT
- yCoord  output  10  vertical counter >> SCALE_SHIFT
- coord_valid  output  1  current xCoord/yCoord lie in the active area (undelayed)
- line_start  output  1  one-clock pulse when the horizontal count is 0 (undelayed)
- frame_start  output  1  one-clock pulse when the position is (0,0) (undelayed)
- VGA_HS  output  1  horizontal sync, delayed PIPE_DELAY
- VGA_VS  output  1  vertical sync, delayed PIPE_DELAY
- visible  output  1  active-area flag, delayed PIPE_DELAY
- VGA_SYNC_N  output  1  constant 1
- pixelClk  output  1  equals vga_clock
- frame_count  output  16  frame counter (optional feature)

Behaviour:
Horizontal FSM:
- States H_ACT → H_FRONT → H_SYN → H_BACK → H_ACT.
- Each state has a phase counter loaded with (length − 1) on entry; the state advances when the phase counter reaches 0.
- A position counter hcount runs 0..H_total−1, where H_total = H_ACTIVE + H_FP + H_SYNC + H_BP.

Vertical FSM:
- Same state structure with V_* lengths and vcount.
- Steps only on the clock where the horizontal FSM leaves H_BACK (end of line).

Decode (undelayed):
- coord_valid = (hstate == H_ACT) && (vstate == V_ACT).
- xCoord = hcount[9:0] >> SCALE_SHIFT; yCoord = vcount[9:0] >> SCALE_SHIFT. Both are raw values and also advance during blanking.
- Defaults: HS asserted for hcount 656..751; VS asserted for vcount 490..491; totals are 800 and 525.

Pipeline:
- Raw HS, VS and valid pass through a PIPE_DELAY-deep register chain.
- Visible-pixel alignment: visible at cycle t+PIPE_DELAY corresponds to the coordinate presented at cycle t.

Reset (resetn low):
- hcount = vcount = 0; both FSMs in *_ACT with phase counters loaded; all pipeline stages cleared.
- Output values: VGA_HS = ~HS_POL, VGA_VS = ~VS_POL, visible = 0, coord_valid = 1, line_start = 1, frame_start = 1, frame_count = 0.

restart:
- Sampled high → next clock equals the first clock after reset release for the counters and FSMs.
- The pipeline is NOT flushed; it drains naturally.

Boundaries:
- Last pixel of the last line: both counters wrap to 0 in the same clock, and frame_start fires.
- restart has priority over wrap.
- Zero-length porches are illegal; an elaboration check errors if any length is 0.

Optional Feature:
- VGA_FRAME_COUNTER_EN defined: frame_count increments on each frame_start after the first post-reset frame. It wraps 0xFFFF→0 and is not cleared by restart.
- Not defined: frame_count is driven constant 0 and no counter register exists.

Decomposition:
- Package vga_timing_pkg holds:
  - phase enum typedef (ACT, FRONT, SYN, BACK);
  - default 640x480@60 timing constants;
  - a function computing total = active + fp + sync + bp.
- Sub-module vga_axis_counter (phase FSM + position counter + step enable + wrap flag), instantiated once for horizontal and once for vertical.

Test Plan:
- Release reset with defaults → VGA_HS low exactly for hcount 656..751 (96 clocks, delayed 2); line period 800 clocks; frame period 420000 clocks.
- SCALE_SHIFT=2 → xCoord repeats each value 4 times; max xCoord during active = 159, max yCoord = 119.
- PIPE_DELAY=3 → visible first rises 3 clocks after coord_valid rises at (0,0).
- HS_POL=1, VS_POL=1 → VGA_HS high for 96 clocks per line; VGA_VS high for 1600 clocks per frame; outputs low in reset.
- restart asserted at hcount=300, vcount=200 → next clock hcount=0, vcount=0, frame_start=1; following frame is a full 420000 clocks.
- With VGA_FRAME_COUNTER_EN, run 3 frames → frame_count 0,1,2,3 at successive frame_starts; with resetn pulsed mid-frame, it returns to 0 asynchronously.
